// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter/rotator: op select and FSM states.
package shift_pkg;

    localparam logic [2:0] SHIFT_OP_SHL  = 3'd0;
    localparam logic [2:0] SHIFT_OP_SHR  = 3'd1;
    localparam logic [2:0] SHIFT_OP_SHRA = 3'd2;
    localparam logic [2:0] SHIFT_OP_ROL  = 3'd3;
    localparam logic [2:0] SHIFT_OP_ROR  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP bits applied to the work value.
module shift_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic [AMT_W:0]   s,
    output logic [WIDTH-1:0] shifted
);
    import shift_pkg::*;

    always_comb begin
        shifted = value;
        case (op)
            SHIFT_OP_SHL:  shifted = value << s;
            SHIFT_OP_SHR:  shifted = value >> s;
            SHIFT_OP_SHRA: shifted = $signed(value) >>> s;
            // A shift by WIDTH yields zero, so s == 0 leaves the rotate as identity.
            SHIFT_OP_ROL:  shifted = (value << s) | (value >> (WIDTH - s));
            SHIFT_OP_ROR:  shifted = (value >> s) | (value << (WIDTH - s));
            default:       shifted = value;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter/rotator with start/finished handshake; shifts up to STEP bits per clock.
module shift_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             finished,
    output logic             busy
);
    import shift_pkg::*;

    // Remaining never exceeds WIDTH-1, so capping STEP there keeps min() exact in AMT_W bits.
    localparam int unsigned     STEP_CAP = (STEP >= WIDTH) ? WIDTH - 1 : STEP;
    localparam logic [AMT_W-1:0] STEP_N  = AMT_W'(STEP_CAP);

    shift_state_e     state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] b_amt;
    logic [AMT_W-1:0] s_n;
    logic [AMT_W:0]   s;
    logic [WIDTH-1:0] step_out;
    logic             unused_b_hi;

    assign unused_b_hi = ^B[WIDTH-1:AMT_W];

    assign b_amt = (op > SHIFT_OP_ROR) ? '0 : B[AMT_W-1:0];
    assign s_n   = (rem_q < STEP_N) ? rem_q : STEP_N;
    assign s     = {1'b0, s_n};

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .op      (op_q),
        .value   (work_q),
        .s       (s),
        .shifted (step_out)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    work_d = A;
                    rem_d  = b_amt;
                    if (b_amt == '0) begin
                        state_d  = DONE;
                        result_d = A;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - s_n;
                if (rem_q == s_n) begin
                    state_d  = DONE;
                    result_d = step_out;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign result   = result_q;
    assign finished = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench: STEP=1 and STEP=4 shifters driven in lockstep, table + random + corner sequences.
module tb_shift_unit_seq;

    logic        Clock;
    logic        clear;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] res1, res4;
    logic        fin1, fin4, busy1, busy4;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev1, prev4;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    shift_unit_seq #(.WIDTH(32), .STEP(1)) u_dut1 (
        .Clock(Clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
        .result(res1), .finished(fin1), .busy(busy1)
    );

    shift_unit_seq #(.WIDTH(32), .STEP(4)) u_dut4 (
        .Clock(Clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
        .result(res4), .finished(fin4), .busy(busy4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int unsigned eff_amt(input logic [2:0] o, input logic [31:0] b);
        if (o > 3'd4) return 0;
        return b % 32;
    endfunction

    function automatic int unsigned lat(input int unsigned n, input int unsigned step);
        return (n + step - 1) / step;
    endfunction

    // Bit-by-bit definition of each operation.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        logic [31:0] r;
        n = eff_amt(o, b);
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (o)
                3'd0: if (i >= n) r[i] = a[i - n];
                3'd1: if (i + n < 32) r[i] = a[i + n];
                3'd2: r[i] = (i + n < 32) ? a[i + n] : a[31];
                3'd3: r[(i + n) % 32] = a[i];
                3'd4: r[i] = a[(i + n) % 32];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input int unsigned cnt, input int unsigned l,
                             input logic [31:0] r_exp, input logic [31:0] prev,
                             input logic [31:0] r, input logic f, input logic bz);
        chk($sformatf("%s_finished_c%0d", tag, cnt), {31'd0, f},  {31'd0, cnt == l + 1});
        chk($sformatf("%s_busy_c%0d", tag, cnt),     {31'd0, bz}, {31'd0, cnt <= l + 1});
        chk($sformatf("%s_result_c%0d", tag, cnt), r, (cnt >= l + 1) ? r_exp : prev);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r_exp, input int unsigned poke_cnt,
                          input logic [31:0] poke_a);
        int unsigned n, l1, l4, last;
        n    = eff_amt(o, b);
        l1   = lat(n, 1);
        l4   = lat(n, 4);
        last = ((l1 > l4) ? l1 : l4) + 2;
        @(negedge Clock);
        start = 1'b1; op = o; A = a; B = b;
        for (int unsigned cnt = 1; cnt <= last; cnt++) begin
            @(negedge Clock);
            chk_cycle("s1", cnt, l1, r_exp, prev1, res1, fin1, busy1);
            chk_cycle("s4", cnt, l4, r_exp, prev4, res4, fin4, busy4);
            if (cnt == 1) begin
                start = 1'b0;
                op = 3'($urandom);
                A  = $urandom;
                B  = $urandom;
            end
            if (poke_cnt != 0 && cnt == poke_cnt) begin
                start = 1'b1;
                A = poke_a;
            end
            if (poke_cnt != 0 && cnt == poke_cnt + 1) start = 1'b0;
        end
        prev1 = r_exp;
        prev4 = r_exp;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0018, 32'd2,  32'h0000_0060};
        vecs[1]  = '{3'd2, 32'h8000_0000, 32'd4,  32'hF800_0000};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'd4,  32'h0800_0000};
        vecs[3]  = '{3'd4, 32'h0000_0001, 32'd1,  32'h8000_0000};
        vecs[4]  = '{3'd3, 32'h8000_0001, 32'd4,  32'h0000_0018};
        vecs[5]  = '{3'd0, 32'h1234_5678, 32'd0,  32'h1234_5678};
        vecs[6]  = '{3'd0, 32'h0000_0001, 32'd35, 32'h0000_0008};
        vecs[7]  = '{3'd4, 32'hA5A5_A5A5, 32'd32, 32'hA5A5_A5A5};
        vecs[8]  = '{3'd7, 32'hDEAD_BEEF, 32'd5,  32'hDEAD_BEEF};
        vecs[9]  = '{3'd2, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF};
        vecs[10] = '{3'd3, 32'h1234_5678, 32'd8,  32'h3456_7812};
        vecs[11] = '{3'd1, 32'hF000_0000, 32'd30, 32'h0000_0003};

        clear = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        prev1 = '0; prev4 = '0;
        @(negedge Clock);
        @(negedge Clock);
        chk("reset_result_s1", res1, 32'h0);
        chk("reset_result_s4", res4, 32'h0);
        chk("reset_flags", {28'd0, fin1, busy1, fin4, busy4}, 32'h0);
        clear = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, '0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb), 0, '0);
        end

        // start pulse with new A while both units are still shifting
        run_op(3'd0, 32'h1, 32'd6, 32'h40, 2, 32'h0000_FFFF);

        // start held high through DONE relaunches from IDLE with current inputs
        @(negedge Clock);
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd2;
        for (int unsigned cnt = 1; cnt <= 8; cnt++) begin
            @(negedge Clock);
            chk($sformatf("hold_fin_s1_c%0d", cnt), {31'd0, fin1}, {31'd0, cnt == 3 || cnt == 7});
            chk($sformatf("hold_fin_s4_c%0d", cnt), {31'd0, fin4}, {31'd0, cnt == 2 || cnt == 5});
            if (cnt == 3) chk("hold_first_s1", res1, 32'd12);
            if (cnt == 7) chk("hold_second_s1", res1, 32'd20);
            if (cnt == 2) chk("hold_first_s4", res4, 32'd12);
            if (cnt == 5) chk("hold_second_s4", res4, 32'd20);
            if (cnt == 8) chk("hold_idle_busy", {30'd0, busy1, busy4}, 32'h0);
            if (cnt == 1) A = 32'd5;
            if (cnt == 5) start = 1'b0;
        end
        prev1 = 32'd20;
        prev4 = 32'd20;

        // asynchronous clear between edges while shifting
        @(negedge Clock);
        start = 1'b1; op = 3'd0; A = 32'h1; B = 32'd20;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        chk("pre_clear_busy", {30'd0, busy1, busy4}, 32'h3);
        clear = 1'b1;
        #1;
        chk("clear_result_s1", res1, 32'h0);
        chk("clear_result_s4", res4, 32'h0);
        chk("clear_flags", {28'd0, fin1, busy1, fin4, busy4}, 32'h0);
        @(negedge Clock);
        clear = 1'b0;
        prev1 = '0;
        prev4 = '0;
        run_op(3'd0, 32'h3, 32'd5, 32'h60, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Multi-cycle, parametrised shifter/rotator used by the datapath ALU for the shl/shr/shra/rol/ror instruction group.
- Uses the same start/finished handshake as the existing ALU path.
- Accepts operand A and a shift amount B, then shifts up to STEP bits per clock.
- Holds the result until the next start.
- Generalises the fixed shift-left path to any width, step size and five shift/rotate modes.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >=8)
STEP, 1, max bits shifted per cycle (power of 2, 1..WIDTH)
AMT_W, $clog2(WIDTH), width of effective shift amount (derived, do not override)

Ports:
Clock  in  1  system clock, rising edge
clear  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE
op  in  3  operation select (see Behaviour)
A  in  WIDTH  value to shift
B  in  WIDTH  shift amount; only B[AMT_W-1:0] used
result  out  WIDTH  shifted value, registered
finished  out  1  one-cycle pulse: result valid
busy  out  1  high in SHIFT and DONE

Behaviour:
- Reset (clear=1, any time, asynchronous): state=IDLE; result=0; finished=0; busy=0; internal amount/op/work registers = 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge k:
  - latch op, work=A, remaining=B[AMT_W-1:0]; amount is B mod WIDTH.
  - remaining==0 -> DONE; otherwise -> SHIFT.
- IDLE, start=0: stay IDLE.
- SHIFT, each edge:
  - s = min(STEP, remaining); work = op(work, s); remaining -= s.
  - new remaining==0 -> DONE; otherwise stay in SHIFT.
- DONE:
  - finished=1 for exactly this one cycle; result holds the final work value, registered on entry.
  - next edge -> IDLE unconditionally.
- Latency: amount n>0 gives finished high in the cycle after edge k+ceil(n/STEP); n==0 gives finished high in the cycle after edge k.
- result changes only on DONE entry. It holds its value through IDLE and through a subsequent SHIFT until the next DONE.
- Op encoding:
  - 0 SHL: logical left, zero fill.
  - 1 SHR: logical right, zero fill.
  - 2 SHRA: arithmetic right, sign fill from work[WIDTH-1].
  - 3 ROL: rotate left.
  - 4 ROR: rotate right.
  - 5-7: NOP; treated as amount 0, result=A, normal handshake.
- start while busy=1 is ignored; no queueing, no error.
- start still high in IDLE after DONE starts a new operation with current inputs. The driver must drop start before DONE if single-shot behaviour is wanted.
- A and B changes after the start edge do not affect the in-flight operation.
- Overshift: B>=WIDTH wraps mod WIDTH by construction, so B=WIDTH behaves as 0.
- Each shift step is purely combinational from work, s and op; no multi-cycle paths.

Decomposition:
- Package shift_pkg holds:
  - op encoding localparams (SHIFT_OP_SHL..SHIFT_OP_ROR, width 3);
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- One sub-module, shift_step: combinational. Inputs op, value[WIDTH], s[AMT_W+1]; output value shifted by s (0..STEP). Instantiated once, feeding work.
- Control FSM and counters stay in shift_unit_seq.

Test Plan:
- WIDTH=32 STEP=1, op=SHL, A=0x00000018, B=2, 20 ns start pulse -> finished one cycle after 2nd SHIFT edge; result=0x00000060; busy low afterwards.
- STEP=4, op=SHRA, A=0x80000000, B=4 -> single SHIFT cycle; result=0xF8000000. Repeat op=SHR -> 0x08000000.
- STEP=1, op=ROR, A=0x00000001, B=1 -> 0x80000000. op=ROL, A=0x80000001, B=4 -> 0x00000018.
- Boundaries:
  - B=0 -> finished in cycle after start edge, result=A.
  - B=35 -> behaves as 3.
  - B=32 -> result=A.
  - op=7 -> result=A with pulse.
- Assert start during SHIFT with new A -> ignored, original result produced. Hold start high through DONE -> second operation launches in IDLE.
- Assert clear mid-SHIFT (between edges) -> result=0, finished=0, busy=0 immediately. A new start after clear drops completes normally.
